// File: rtl/control_unit_pkg.sv
// Shared types and constants for the control unit: state encoding, opcodes and ALU codes.
// Build option CONTROL_UNIT_JZ_EN adds the JZ opcode and its JUMP state.
package control_unit_pkg;

  typedef enum logic [3:0] {
    ST_INIT   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_NOOP   = 4'd3,
    ST_LOAD_A = 4'd4,
    ST_LOAD_B = 4'd5,
    ST_STORE  = 4'd6,
    ST_ADD    = 4'd7,
    ST_SUB    = 4'd8,
`ifdef CONTROL_UNIT_JZ_EN
    ST_HALT   = 4'd9,
    ST_JUMP   = 4'd10
`else
    ST_HALT   = 4'd9
`endif
  } state_t;

  localparam logic [3:0] OP_NOOP  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_LOAD  = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_HALT  = 4'b0101;
  localparam logic [3:0] OP_JZ    = 4'b0110;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

  function automatic logic [3:0] opcode_of(input logic [15:0] instr);
    return instr[15:12];
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Bus between the control unit and its instruction memory, data memory and datapath.
interface control_unit_if;
  logic [15:0] i_data;
  logic        ra_zero;
  logic [6:0]  i_addr;
  logic [7:0]  d_addr;
  logic        d_wr;
  logic        rf_s;
  logic [3:0]  rf_w_addr;
  logic [3:0]  rf_ra_addr;
  logic [3:0]  rf_rb_addr;
  logic        rf_w_en;
  logic [2:0]  alu_s0;
  logic [3:0]  state;

  modport master (
    input  i_data, ra_zero,
    output i_addr, d_addr, d_wr, rf_s, rf_w_addr, rf_ra_addr, rf_rb_addr,
           rf_w_en, alu_s0, state
  );

  modport slave (
    output i_data, ra_zero,
    input  i_addr, d_addr, d_wr, rf_s, rf_w_addr, rf_ra_addr, rf_rb_addr,
           rf_w_en, alu_s0, state
  );
endinterface

// File: rtl/control_unit_program_counter.sv
// 7-bit program counter with clear, load and increment; wraps 127 -> 0 naturally.
module program_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       inc,
  input  logic       load,
  input  logic [6:0] load_value,
  output logic [6:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= 7'd0;
    end else if (clear) begin
      pc <= 7'd0;
    end else if (load) begin
      pc <= load_value;
    end else if (inc) begin
      pc <= pc + 7'd1;
    end
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer: fetch, decode and execute FSM with registered control outputs.
// Defining CONTROL_UNIT_JZ_EN adds the JZ (jump-if-zero) instruction.
module control_unit
  import control_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  control_unit_if.master     bus
);

  state_t      state_reg;
  logic [15:0] ir_reg;
  logic        init_wait_reg;
  logic        d_wr_reg;
  logic        rf_s_reg;
  logic        rf_w_en_reg;
  logic [2:0]  alu_s0_reg;
  logic [3:0]  rf_ra_addr_reg;
  logic [3:0]  rf_rb_addr_reg;
  logic [3:0]  rf_w_addr_reg;

  logic        pc_clear;
  logic        pc_inc;
  logic        pc_load;
  logic [6:0]  pc;

  assign pc_clear = (state_reg == ST_INIT);
  assign pc_inc   = (state_reg == ST_FETCH);
`ifdef CONTROL_UNIT_JZ_EN
  assign pc_load  = (state_reg == ST_JUMP) && bus.ra_zero;
`else
  assign pc_load  = 1'b0;
  wire unused_ra_zero = &{1'b0, bus.ra_zero};
`endif

  program_counter u_pc (
    .clk        (clk),
    .rst        (rst),
    .clear      (pc_clear),
    .inc        (pc_inc),
    .load       (pc_load),
    .load_value (ir_reg[6:0]),
    .pc         (pc)
  );

  // Outputs are registered alongside the state, so they are set for the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_INIT;
      ir_reg         <= 16'd0;
      init_wait_reg  <= 1'b0;
      d_wr_reg       <= 1'b0;
      rf_s_reg       <= 1'b0;
      rf_w_en_reg    <= 1'b0;
      alu_s0_reg     <= ALU_PASS;
      rf_ra_addr_reg <= 4'd0;
      rf_rb_addr_reg <= 4'd0;
      rf_w_addr_reg  <= 4'd0;
    end else begin
      d_wr_reg       <= 1'b0;
      rf_s_reg       <= 1'b0;
      rf_w_en_reg    <= 1'b0;
      alu_s0_reg     <= ALU_PASS;
      rf_ra_addr_reg <= 4'd0;
      rf_rb_addr_reg <= 4'd0;
      rf_w_addr_reg  <= 4'd0;

      case (state_reg)
        // INIT lingers one extra cycle so the first FETCH lands on the second edge.
        ST_INIT: begin
          if (init_wait_reg) begin
            state_reg <= ST_FETCH;
          end else begin
            init_wait_reg <= 1'b1;
          end
        end
        ST_FETCH: begin
          ir_reg    <= bus.i_data;
          state_reg <= ST_DECODE;
        end
        ST_DECODE: begin
          case (opcode_of(ir_reg))
            OP_STORE: begin
              state_reg      <= ST_STORE;
              d_wr_reg       <= 1'b1;
              rf_ra_addr_reg <= ir_reg[3:0];
            end
            OP_LOAD:  state_reg <= ST_LOAD_A;
            OP_ADD: begin
              state_reg      <= ST_ADD;
              alu_s0_reg     <= ALU_ADD;
              rf_w_en_reg    <= 1'b1;
              rf_ra_addr_reg <= ir_reg[11:8];
              rf_rb_addr_reg <= ir_reg[7:4];
              rf_w_addr_reg  <= ir_reg[3:0];
            end
            OP_SUB: begin
              state_reg      <= ST_SUB;
              alu_s0_reg     <= ALU_SUB;
              rf_w_en_reg    <= 1'b1;
              rf_ra_addr_reg <= ir_reg[11:8];
              rf_rb_addr_reg <= ir_reg[7:4];
              rf_w_addr_reg  <= ir_reg[3:0];
            end
            OP_HALT:  state_reg <= ST_HALT;
`ifdef CONTROL_UNIT_JZ_EN
            OP_JZ: begin
              state_reg      <= ST_JUMP;
              rf_ra_addr_reg <= ir_reg[11:8];
            end
`endif
            default:  state_reg <= ST_NOOP;
          endcase
        end
        // Memory read was issued in LOAD_A; the data is written back here.
        ST_LOAD_A: begin
          state_reg     <= ST_LOAD_B;
          rf_s_reg      <= 1'b1;
          rf_w_en_reg   <= 1'b1;
          rf_w_addr_reg <= ir_reg[3:0];
        end
        ST_NOOP, ST_LOAD_B, ST_STORE, ST_ADD, ST_SUB: state_reg <= ST_FETCH;
`ifdef CONTROL_UNIT_JZ_EN
        ST_JUMP:  state_reg <= ST_FETCH;
`endif
        ST_HALT:  state_reg <= ST_HALT;
        default:  state_reg <= ST_INIT;
      endcase
    end
  end

  assign bus.i_addr     = pc;
  assign bus.d_addr     = ir_reg[11:4];
  assign bus.d_wr       = d_wr_reg;
  assign bus.rf_s       = rf_s_reg;
  assign bus.rf_w_en    = rf_w_en_reg;
  assign bus.alu_s0     = alu_s0_reg;
  assign bus.rf_ra_addr = rf_ra_addr_reg;
  assign bus.rf_rb_addr = rf_rb_addr_reg;
  assign bus.rf_w_addr  = rf_w_addr_reg;
  assign bus.state      = state_reg;

endmodule

// File: tb/tb_control_unit.sv
// Directed scoreboard bench for control_unit: expected per-cycle outputs are queued, then
// popped and compared one cycle later against the observed bus.
module tb_control_unit;
  import control_unit_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic [6:0] pc;
    logic [7:0] da;
    logic       dwr;
    logic       rfs;
    logic       wen;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] w;
    logic [2:0] alu;
  } exp_t;

  logic clk;
  logic rst;
  control_unit_if bus();

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  control_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input state_t st, input logic [6:0] pc, input logic [7:0] da,
                              input logic dwr, input logic rfs, input logic wen,
                              input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] w,
                              input logic [2:0] alu);
    exp_t e;
    e.st = st; e.pc = pc; e.da = da; e.dwr = dwr; e.rfs = rfs; e.wen = wen;
    e.ra = ra; e.rb = rb; e.w = w; e.alu = alu;
    return e;
  endfunction

  // Idle-control expectation: only state, PC and data address vary.
  function automatic exp_t idle(input state_t st, input logic [6:0] pc, input logic [7:0] da);
    return mk(st, pc, da, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, ALU_PASS);
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o.st = bus.state; o.pc = bus.i_addr; o.da = bus.d_addr; o.dwr = bus.d_wr;
    o.rfs = bus.rf_s; o.wen = bus.rf_w_en; o.ra = bus.rf_ra_addr; o.rb = bus.rf_rb_addr;
    o.w = bus.rf_w_addr; o.alu = bus.alu_s0;
    return o;
  endfunction

  task automatic compare(input string tag);
    exp_t e;
    exp_t o;
    e = sb.pop_front();
    o = observe();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed st=%0d pc=%0d da=%h dwr=%b rfs=%b wen=%b ra=%h rb=%h w=%h alu=%b required st=%0d pc=%0d da=%h dwr=%b rfs=%b wen=%b ra=%h rb=%h w=%h alu=%b",
             tag, o.st, o.pc, o.da, o.dwr, o.rfs, o.wen, o.ra, o.rb, o.w, o.alu,
             e.st, e.pc, e.da, e.dwr, e.rfs, e.wen, e.ra, e.rb, e.w, e.alu);
    end
  endtask

  task automatic step(input string tag, input exp_t e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare(tag);
    $display("cycle %s st=%0d pc=%0d", tag, bus.state, bus.i_addr);
  endtask

  task automatic chk_now(input string tag, input exp_t e);
    sb.push_back(e);
    compare(tag);
    $display("check %s st=%0d pc=%0d", tag, bus.state, bus.i_addr);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_data = 16'h0000;
    bus.ra_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_now("reset", idle(ST_INIT, 7'd0, 8'h00));
    @(negedge clk);
    rst = 1'b0;

    // NOOP stream
    step("init_hold", idle(ST_INIT,   7'd0, 8'h00));
    step("fetch0",    idle(ST_FETCH,  7'd0, 8'h00));
    step("decode0",   idle(ST_DECODE, 7'd1, 8'h00));
    step("noop0",     idle(ST_NOOP,   7'd1, 8'h00));
    step("fetch1",    idle(ST_FETCH,  7'd1, 8'h00));
    step("decode1",   idle(ST_DECODE, 7'd2, 8'h00));
    step("noop1",     idle(ST_NOOP,   7'd2, 8'h00));
    step("fetch2",    idle(ST_FETCH,  7'd2, 8'h00));

    // LOAD: four cycles FETCH to FETCH
    bus.i_data = 16'h21B5;
    step("ld_decode", idle(ST_DECODE, 7'd3, 8'h1B));
    step("ld_a",      idle(ST_LOAD_A, 7'd3, 8'h1B));
    step("ld_b",      mk(ST_LOAD_B, 7'd3, 8'h1B, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 4'd5, ALU_PASS));
    step("ld_fetch",  idle(ST_FETCH,  7'd3, 8'h1B));

    // STORE
    bus.i_data = 16'h11B5;
    step("st_decode", idle(ST_DECODE, 7'd4, 8'h1B));
    step("st_exec",   mk(ST_STORE, 7'd4, 8'h1B, 1'b1, 1'b0, 1'b0, 4'd5, 4'd0, 4'd0, ALU_PASS));
    step("st_fetch",  idle(ST_FETCH,  7'd4, 8'h1B));

    // ADD and SUB
    bus.i_data = 16'h3123;
    step("add_decode", idle(ST_DECODE, 7'd5, 8'h12));
    step("add_exec",   mk(ST_ADD, 7'd5, 8'h12, 1'b0, 1'b0, 1'b1, 4'd1, 4'd2, 4'd3, 3'b001));
    step("add_fetch",  idle(ST_FETCH,  7'd5, 8'h12));
    bus.i_data = 16'h4123;
    step("sub_decode", idle(ST_DECODE, 7'd6, 8'h12));
    step("sub_exec",   mk(ST_SUB, 7'd6, 8'h12, 1'b0, 1'b0, 1'b1, 4'd1, 4'd2, 4'd3, 3'b010));
    step("sub_fetch",  idle(ST_FETCH,  7'd6, 8'h12));

    // Undefined opcode behaves as NOOP
    bus.i_data = 16'hF0A0;
    step("unk_decode", idle(ST_DECODE, 7'd7, 8'h0A));
    step("unk_exec",   idle(ST_NOOP,   7'd7, 8'h0A));
    step("unk_fetch",  idle(ST_FETCH,  7'd7, 8'h0A));

    // Opcode 0110: JZ when enabled, otherwise NOOP
    bus.i_data = 16'h6A0F;
    bus.ra_zero = 1'b1;
`ifdef CONTROL_UNIT_JZ_EN
    step("jz_t_decode", idle(ST_DECODE, 7'd8, 8'hA0));
    step("jz_t_exec",   mk(ST_JUMP, 7'd8, 8'hA0, 1'b0, 1'b0, 1'b0, 4'hA, 4'd0, 4'd0, ALU_PASS));
    step("jz_t_fetch",  idle(ST_FETCH,  7'd15, 8'hA0));
    bus.ra_zero = 1'b0;
    step("jz_n_decode", idle(ST_DECODE, 7'd16, 8'hA0));
    step("jz_n_exec",   mk(ST_JUMP, 7'd16, 8'hA0, 1'b0, 1'b0, 1'b0, 4'hA, 4'd0, 4'd0, ALU_PASS));
    step("jz_n_fetch",  idle(ST_FETCH,  7'd16, 8'hA0));
`else
    step("op6_decode", idle(ST_DECODE, 7'd8, 8'hA0));
    step("op6_exec",   idle(ST_NOOP,   7'd8, 8'hA0));
    step("op6_fetch",  idle(ST_FETCH,  7'd8, 8'hA0));
    bus.ra_zero = 1'b0;
    step("op6b_decode", idle(ST_DECODE, 7'd9, 8'hA0));
    step("op6b_exec",   idle(ST_NOOP,   7'd9, 8'hA0));
    step("op6b_fetch",  idle(ST_FETCH,  7'd9, 8'hA0));
`endif

    // Reset in the middle of a LOAD
    bus.i_data = 16'h21B5;
    step("rl_decode", idle(ST_DECODE, bus.i_addr + 7'd1, 8'h1B));
    step("rl_a",      idle(ST_LOAD_A, bus.i_addr, 8'h1B));
    rst = 1'b1;
    #1;
    chk_now("rst_mid_load", idle(ST_INIT, 7'd0, 8'h00));
    @(negedge clk);
    rst = 1'b0;
    bus.i_data = 16'h0000;
    step("rl_init",  idle(ST_INIT,  7'd0, 8'h00));
    step("rl_fetch", idle(ST_FETCH, 7'd0, 8'h00));

    // Run NOOPs until the PC wraps 127 -> 0
    for (int n = 1; n <= 128; n++) begin
      repeat (3) @(posedge clk);
      #1;
      chk_now($sformatf("wrap_fetch%0d", n), idle(ST_FETCH, 7'(n), 8'h00));
    end

    // HALT freezes the PC
    bus.i_data = 16'h5000;
    step("halt_decode", idle(ST_DECODE, 7'd1, 8'h00));
    for (int k = 0; k < 20; k++) begin
      bus.i_data = 16'h3123;
      step($sformatf("halt%0d", k), idle(ST_HALT, 7'd1, 8'h00));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
